bfly_inject_tx: RTL and testbench
=================================

Name: bfly_inject_tx

Overview:
- Terminal-side transmitter feeding one input channel of the 64-port radix-4 symmetrical butterfly.
- Accepts a client word stream with a destination port and frames it into CHANNEL_WIDTH-bit flits: one head flit carrying the route, then body flits, closed by a tail flit.
- Paces injection with credit-based flow control against the first-layer switch node's input buffer.
- One instance per network input port; output drives one in_ch lane.

Parameters:
- PORTS, 64, network port count; DEST_W = $clog2(PORTS) = 6 (three radix-4 route digits).
- CHANNEL_WIDTH, 18, flit width; DATA_W = CHANNEL_WIDTH-2 = 16.
- CREDITS, 4, downstream buffer depth in flits; counter width $clog2(CREDITS+1).
- MAX_PAYLOAD, 8, maximum payload flits per packet.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  client word valid.
- req_ready  output  1  client word accepted when req_valid & req_ready.
- req_dest  input  DEST_W  destination port; sampled only at packet start.
- req_data  input  DATA_W  payload word.
- req_last  input  1  marks final payload word of the packet.
- credit_in  input  1  one-cycle pulse; one downstream buffer slot freed.
- out_ch  output  CHANNEL_WIDTH  flit to switch; registered.
- credits  output  $clog2(CREDITS+1)  current credit count.
- pkt_count  output  16  packets completed (tail flits sent); wraps at 2^16.
- err_len  output  1  sticky; set when a packet is truncated at MAX_PAYLOAD.
- err_credit  output  1  sticky; set on credit_in while credits==CREDITS.

Behaviour:
- Flit format, out_ch[17:16] type:
  - 00 idle, all bits zero.
  - 01 head: [15:6]=0, [5:0]=dest; stage-1 route digit dest[5:4], stage-2 dest[3:2], stage-3 dest[1:0].
  - 10 body: [15:0]=data.
  - 11 tail: [15:0]=data.
- Reset values: out_ch=0, credits=CREDITS, pkt_count=0, err_len=0, err_credit=0, FSM=IDLE, word counter=0, req_ready=0.
- FSM states:
  - IDLE: req_ready=0. If req_valid and credits>0: register head flit with req_dest, latch dest, go to PAYLOAD. No client word is consumed. Otherwise out_ch=idle.
  - PAYLOAD: req_ready = (credits>0). On accept, emit body or tail with req_data and increment the word counter.
    - Tail if req_last=1 or word counter reaches MAX_PAYLOAD.
    - On tail: pkt_count+1, counter cleared, go to IDLE.
    - If the tail was forced (counter==MAX_PAYLOAD and req_last=0): set err_len. The remaining words form a new packet, using req_dest as presented when IDLE next accepts.
  - Any cycle with no flit sent drives out_ch=0; this includes a stall inside a packet.
- Latency: a flit appears on out_ch the cycle after the head decision or word acceptance.
- Minimum packet is head+tail (2 flits). Back-to-back packets leave no idle gap: the IDLE head is emitted in the cycle after the tail.
- Credits:
  - Each non-idle flit sent decrements.
  - credit_in increments.
  - Both in the same cycle: unchanged.
  - credit_in at CREDITS: saturate and set err_credit.
  - Never send at credits==0; the count never underflows.
- req_dest changing mid-packet is ignored; the latched dest is used.
- rst mid-packet: packet abandoned, no tail emitted, all state to reset values next cycle.
- Combinational path from credits/FSM to req_ready only; no path from req_valid to req_ready.

Test Plan:
- Reset, then dest=0x2D, words 0x1111 and 0x2222 (last on 2nd), credit_in held low → out_ch: 0x1002D, 0x21111, 0x32222. credits 4→1, pkt_count=1.
- CREDITS=4, 6-word packet, no credit_in → head + 3 body, then out_ch idle and req_ready=0. Pulse credit_in twice → 2 more flits sent, credits=0.
- 10 words with req_last never set → tail at 8th payload word, err_len=1. Word 9 starts a new head with the current req_dest.
- credit_in pulsed with credits=4 → credits stays 4, err_credit=1. credit_in coincident with a flit send at credits=2 → credits stays 2.
- Assert rst after head+1 body → next cycle out_ch=0, credits=4, FSM idle. A fresh packet framed correctly afterwards.
- Two back-to-back 1-word packets to dest 0x00 and 0x3F with ample credits → flits 0x10000, 0x3xxxx, 0x1003F, 0x3xxxx on consecutive cycles, pkt_count=2.

Source files
------------

// File: rtl/bfly_inject_tx.sv
`default_nettype none
// ============================================================================
// Module   : bfly_inject_tx
// Purpose  : Frames a client word stream into head/body/tail flits and paces
//            injection into a butterfly input lane with credit flow control.
// Revision : 1.0
// ============================================================================
module bfly_inject_tx #(
    parameter  int PORTS         = 64,
    parameter  int CHANNEL_WIDTH = 18,
    parameter  int CREDITS       = 4,
    parameter  int MAX_PAYLOAD   = 8,
    localparam int DEST_W        = $clog2(PORTS),
    localparam int DATA_W        = CHANNEL_WIDTH - 2,
    localparam int CRED_W        = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [DEST_W-1:0]        req_dest,
    input  logic [DATA_W-1:0]        req_data,
    input  logic                     req_last,
    input  logic                     credit_in,
    output logic [CHANNEL_WIDTH-1:0] out_ch,
    output logic [CRED_W-1:0]        credits,
    output logic [15:0]              pkt_count,
    output logic                     err_len,
    output logic                     err_credit
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + 1);

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PAYLOAD = 1'b1
    } state_t;

    state_t                   state_q,      state_d;
    logic [CNT_W-1:0]         cnt_q,        cnt_d;
    logic [CHANNEL_WIDTH-1:0] out_ch_q,     out_ch_d;
    logic [CRED_W-1:0]        credits_q,    credits_d;
    logic [15:0]              pkt_count_q,  pkt_count_d;
    logic                     err_len_q,    err_len_d;
    logic                     err_credit_q, err_credit_d;

    logic             send;
    logic             tail;
    logic             have_credit;
    logic             credits_full;
    logic [CNT_W-1:0] cnt_inc;

    assign have_credit  = (credits_q != '0);
    assign credits_full = (credits_q == CRED_W'(CREDITS));
    assign req_ready    = (state_q == S_PAYLOAD) && have_credit;
    assign cnt_inc      = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        out_ch_d     = '0;
        pkt_count_d  = pkt_count_q;
        err_len_d    = err_len_q;
        err_credit_d = err_credit_q;
        send         = 1'b0;
        tail         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The head carries the whole route, so the destination never
                // needs to be held once the head has been registered.
                if (req_valid && have_credit) begin
                    out_ch_d = {TYPE_HEAD, {(DATA_W-DEST_W){1'b0}}, req_dest};
                    send     = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (req_valid && req_ready) begin
                    send     = 1'b1;
                    tail     = req_last || (cnt_inc == CNT_W'(MAX_PAYLOAD));
                    out_ch_d = {(tail ? TYPE_TAIL : TYPE_BODY), req_data};
                    if (tail) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        cnt_d       = '0;
                        state_d     = S_IDLE;
                        if (!req_last) begin
                            err_len_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A returned credit while already full is a protocol error; the count
        // saturates rather than wrapping.
        credits_d = credits_q;
        if (credit_in && credits_full) begin
            err_credit_d = 1'b1;
        end
        case ({send, credit_in})
            2'b10:   credits_d = credits_q - CRED_W'(1);
            2'b01:   credits_d = credits_full ? credits_q : credits_q + CRED_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            out_ch_q     <= '0;
            credits_q    <= CRED_W'(CREDITS);
            pkt_count_q  <= '0;
            err_len_q    <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_ch_q     <= out_ch_d;
            credits_q    <= credits_d;
            pkt_count_q  <= pkt_count_d;
            err_len_q    <= err_len_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign out_ch     = out_ch_q;
    assign credits    = credits_q;
    assign pkt_count  = pkt_count_q;
    assign err_len    = err_len_q;
    assign err_credit = err_credit_q;

endmodule
`default_nettype wire

// File: tb/tb_bfly_inject_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly_inject_tx
// Purpose  : Self-checking bench for bfly_inject_tx (vectors + random vs model).
// Revision : 1.0
// ============================================================================
module tb_bfly_inject_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_dest = '0;
    logic [15:0] req_data = '0;
    logic        req_last = 1'b0;
    logic        credit_in = 1'b0;
    logic [17:0] out_ch;
    logic [2:0]  credits;
    logic [15:0] pkt_count;
    logic        err_len;
    logic        err_credit;

    always #5 clk = ~clk;

    bfly_inject_tx dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_data   (req_data),
        .req_last   (req_last),
        .credit_in  (credit_in),
        .out_ch     (out_ch),
        .credits    (credits),
        .pkt_count  (pkt_count),
        .err_len    (err_len),
        .err_credit (err_credit)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: packet-level view of the transmitter.
    bit          m_sync  = 1'b0;
    bit          m_inpkt = 1'b0;
    int          m_cnt   = 0;
    int          m_cred  = 4;
    int          m_pkt   = 0;
    bit          m_errl  = 1'b0;
    bit          m_errc  = 1'b0;
    logic [17:0] m_out   = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [5:0] d,
                              input logic [15:0] dat, input bit l, input bit c);
        bit sent;
        bit is_tail;
        if (r) begin
            m_sync = 1'b1; m_inpkt = 1'b0; m_cnt = 0; m_cred = 4;
            m_pkt = 0; m_errl = 1'b0; m_errc = 1'b0; m_out = '0;
            return;
        end
        sent  = 1'b0;
        m_out = '0;
        if (!m_inpkt) begin
            if (v && m_cred > 0) begin
                m_out   = {2'b01, 10'd0, d};
                sent    = 1'b1;
                m_inpkt = 1'b1;
                m_cnt   = 0;
            end
        end else if (v && m_cred > 0) begin
            m_cnt++;
            is_tail = l || (m_cnt == 8);
            m_out   = {(is_tail ? 2'b11 : 2'b10), dat};
            sent    = 1'b1;
            if (is_tail) begin
                m_pkt   = (m_pkt + 1) % 65536;
                m_inpkt = 1'b0;
                if (!l) m_errl = 1'b1;
            end
        end
        if (c && m_cred == 4) m_errc = 1'b1;
        m_cred = m_cred - int'(sent) + int'(c);
        if (m_cred > 4) m_cred = 4;
    endtask

    // One clock: drive inputs at negedge, check ready, then check registered
    // outputs just after the rising edge.
    task automatic drive(input bit r, input bit v, input logic [5:0] d,
                         input logic [15:0] dat, input bit l, input bit c,
                         output bit rdy);
        @(negedge clk);
        rst = r; req_valid = v; req_dest = d; req_data = dat;
        req_last = l; credit_in = c;
        #1;
        rdy = req_ready;
        if (m_sync) chk("req_ready", req_ready, longint'(m_inpkt && m_cred > 0));
        model_step(r, v, d, dat, l, c);
        @(posedge clk);
        #1;
        chk("out_ch",     out_ch,     m_out);
        chk("credits",    credits,    m_cred);
        chk("pkt_count",  pkt_count,  m_pkt);
        chk("err_len",    err_len,    m_errl);
        chk("err_credit", err_credit, m_errc);
    endtask

    typedef struct {
        bit          v;
        logic [5:0]  dest;
        logic [15:0] data;
        bit          last;
        bit          cr;
        bit          e_ready;
        logic [17:0] e_out;
        int          e_cred;
        int          e_pkt;
    } vec_t;

    vec_t tbl[12];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        bit          rdy;
        bit          acc;
        int          k;
        int          guard;
        logic [5:0]  dst;

        // Framing, credit return at zero, and back-to-back single-word packets.
        tbl[0]  = '{1'b1, 6'h2D, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h1002D, 3, 0};
        tbl[1]  = '{1'b1, 6'h2D, 16'h1111, 1'b0, 1'b0, 1'b1, 18'h21111, 2, 0};
        tbl[2]  = '{1'b1, 6'h2D, 16'h2222, 1'b1, 1'b0, 1'b1, 18'h32222, 1, 1};
        tbl[3]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h00000, 1, 1};
        tbl[4]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 18'h00000, 2, 1};
        tbl[5]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 18'h00000, 3, 1};
        tbl[6]  = '{1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 18'h00000, 4, 1};
        tbl[7]  = '{1'b1, 6'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h10000, 3, 1};
        tbl[8]  = '{1'b1, 6'h00, 16'hAAAA, 1'b1, 1'b0, 1'b1, 18'h3AAAA, 2, 2};
        tbl[9]  = '{1'b1, 6'h3F, 16'h0000, 1'b0, 1'b0, 1'b0, 18'h1003F, 1, 2};
        tbl[10] = '{1'b1, 6'h3F, 16'h5555, 1'b1, 1'b0, 1'b1, 18'h35555, 0, 3};
        tbl[11] = '{1'b1, 6'h07, 16'h0000, 1'b0, 1'b1, 1'b0, 18'h00000, 1, 3};

        drive(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 1'b0, rdy);
        chk("reset_out_ch",  out_ch,    0);
        chk("reset_credits", credits,   4);
        chk("reset_pkt",     pkt_count, 0);
        chk("reset_errs",    {err_len, err_credit}, 0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].last, tbl[i].cr, rdy);
            chk($sformatf("vec%0d_ready", i),   rdy,       tbl[i].e_ready);
            chk($sformatf("vec%0d_out", i),     out_ch,    tbl[i].e_out);
            chk($sformatf("vec%0d_credits", i), credits,   tbl[i].e_cred);
            chk($sformatf("vec%0d_pkt", i),     pkt_count, tbl[i].e_pkt);
        end

        // Credit exhaustion inside a 6-word packet, then two credit pulses.
        drive(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b1, 6'h05, 16'h0, 1'b0, 1'b0, rdy);
        for (int w = 0; w < 3; w++)
            drive(1'b0, 1'b1, 6'h05, 16'(16'hA000 + w), 1'b0, 1'b0, rdy);
        chk("exhaust_credits", credits, 0);
        drive(1'b0, 1'b1, 6'h05, 16'hA003, 1'b0, 1'b0, rdy);
        chk("stall_ready", rdy, 0);
        chk("stall_out",   out_ch, 0);
        drive(1'b0, 1'b1, 6'h05, 16'hA003, 1'b0, 1'b1, rdy);
        chk("credit1_out", out_ch, 0);
        drive(1'b0, 1'b1, 6'h05, 16'hA003, 1'b0, 1'b1, rdy);
        chk("resume_out",  out_ch, 18'h2A003);
        drive(1'b0, 1'b1, 6'h05, 16'hA004, 1'b0, 1'b0, rdy);
        chk("resume2_out", out_ch, 18'h2A004);
        chk("resume_credits", credits, 0);

        // Ten words without last: forced tail at the 8th, word 9 re-heads.
        drive(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 1'b0, rdy);
        k = 0; guard = 0; dst = 6'h0A;
        while (k < 10 && guard < 80) begin
            guard++;
            acc = m_inpkt && m_cred > 0;
            drive(1'b0, 1'b1, dst, 16'(16'h0100 + k), 1'b0, m_cred < 4, rdy);
            if (acc) begin
                if (k == 7) begin
                    chk("forced_tail", out_ch, 18'h30107);
                    chk("err_len_set", err_len, 1);
                    dst = 6'h12;
                end
                k++;
            end else if (k == 8 && m_inpkt) begin
                chk("rehead_dest", out_ch, 18'h10012);
            end
        end
        chk("long_pkt_words", k, 10);

        // Credit overflow and simultaneous send + return.
        drive(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b0, 6'h0, 16'h0, 1'b0, 1'b1, rdy);
        chk("overflow_credits", credits, 4);
        chk("overflow_err",     err_credit, 1);
        drive(1'b0, 1'b1, 6'h01, 16'h0, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b1, 6'h01, 16'h0C01, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b1, 6'h01, 16'h0C02, 1'b0, 1'b1, rdy);
        chk("send_and_return", credits, 2);

        // Reset mid-packet, then a clean packet.
        drive(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b1, 6'h09, 16'h0, 1'b0, 1'b0, rdy);
        drive(1'b0, 1'b1, 6'h09, 16'hD001, 1'b0, 1'b0, rdy);
        drive(1'b1, 1'b1, 6'h09, 16'hD002, 1'b0, 1'b0, rdy);
        chk("midrst_out",     out_ch, 0);
        chk("midrst_credits", credits, 4);
        drive(1'b0, 1'b0, 6'h21, 16'h0, 1'b0, 1'b0, rdy);
        chk("midrst_idle_ready", rdy, 0);
        drive(1'b0, 1'b1, 6'h21, 16'h0, 1'b0, 1'b0, rdy);
        chk("fresh_head", out_ch, 18'h10021);
        drive(1'b0, 1'b1, 6'h3C, 16'hBEEF, 1'b1, 1'b0, rdy);
        chk("fresh_tail", out_ch, 18'h3BEEF);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 8,
                  6'($urandom),
                  16'($urandom),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
